mod_sub_arbiter: RTL
====================

Name: mod_sub_arbiter

Overview:
Round-robin arbiter and result buffer that shares one modular subtractor, diff = (a - b) mod p, among NREQ requesters in the Lagrange interpolation datapath. The requesters are denominator builders computing (x_j - x_i) and share-correction units. The block accepts one operand pair per cycle, computes the difference, and returns it tagged with the requester ID through a single-entry output register with valid/ready backpressure.

Parameters:
WIDTH, 256, operand/modulus width in bits
NREQ, 4, number of requesters (2..16)
IDW, clog2(NREQ), requester ID width

Ports:
clk  input  1  clock, all state on rising edge
rst  input  1  synchronous reset, active-high
p  input  WIDTH  modulus, sampled in the grant cycle
req_valid  input  NREQ  per-requester operand valid
req_ready  output  NREQ  per-requester grant, one-hot or zero
req_a  input  NREQ*WIDTH  minuends; requester k occupies bits [k*WIDTH +: WIDTH]
req_b  input  NREQ*WIDTH  subtrahends, same packing as req_a
rsp_valid  output  1  result register holds a result
rsp_ready  input  1  consumer accepts result
rsp_id  output  IDW  requester index of held result
rsp_diff  output  WIDTH  (a - b) mod p
rsp_err  output  1  held result came from a >= p or b >= p
op_count  output  32  completed handshakes on rsp, wraps at 2^32

Behaviour:
- Reset (rst=1 at clk edge): rsp_valid=0, rsp_id=0, rsp_diff=0, rsp_err=0, op_count=0, priority pointer ptr=0. Reset drops any held result. rst has priority over all other events in the same cycle.
- Slot free condition: slot_free = !rsp_valid || rsp_ready.
- Grant is combinational. If slot_free and any req_valid is set, grant the first set req_valid[k] searching k = ptr, ptr+1, ... mod NREQ. Only req_ready[k] is asserted. If not slot_free, req_ready is all zero.
- req_ready depends combinationally on req_valid. Requesters must not make req_valid depend on req_ready.
- Handshake: transfer when req_valid[k] && req_ready[k]. Requesters hold a/b stable while valid and not granted.
- On transfer at edge N:
  - rsp_valid=1, rsp_id=k, rsp_err=(a>=p)||(b>=p).
  - rsp_diff = a-b if a>=b; otherwise (a-b+p) truncated to WIDTH bits.
  - ptr = (k+1) mod NREQ.
  - Latency is one cycle: result is visible after edge N.
- Unreduced operands (a or b >= p) still produce the formula result, unreduced, with rsp_err=1.
- Response:
  - rsp_valid && rsp_ready with no new transfer: rsp_valid=0, op_count+1.
  - Response handshake and new transfer in the same cycle: the register is overwritten with the new result, rsp_valid stays 1, op_count+1. Full throughput is one result per cycle.
- Backpressure: while rsp_valid && !rsp_ready, rsp_id/rsp_diff/rsp_err are held constant and no grant is issued.
- ptr advances only on a grant. Idle cycles do not move it.
- Changing p between grants affects only later grants.
- Two-state machine, derived from rsp_valid:
  - EMPTY -> FULL on transfer.
  - FULL -> EMPTY on response handshake without transfer.
  - FULL -> FULL on simultaneous response and transfer, or on stall.

Test Plan:
1. Reset, then check outputs: all outputs 0 and req_ready=0. Then p=97, req0 a=10 b=30 -> req_ready=0001; next cycle rsp_valid=1, rsp_id=0, rsp_diff=77, rsp_err=0.
2. Fairness: all four req_valid held high with rsp_ready=1 -> grants 0,1,2,3,0 on consecutive cycles; rsp_id follows; op_count=5 after 5 response handshakes.
3. Backpressure: result pending with rsp_ready=0 for 3 cycles and req2 valid -> req_ready=0 and rsp_* stable. Raise rsp_ready -> req2 granted same cycle, new result replaces old next cycle, op_count+1.
4. Boundaries with p=97:
   - a=b=50 -> diff 0
   - a=96 b=0 -> 96
   - a=0 b=96 -> 1
   - a=100 b=3 -> diff 97, rsp_err=1
5. Wrap carry with WIDTH=256 and p=2^256-189: a=0, b=1 -> rsp_diff=p-1; overflow is discarded correctly.
6. Reset mid-operation: rsp_valid=1 with ptr=2, assert rst one cycle -> rsp_valid=0, op_count=0. Next grant with req1 and req3 valid goes to req1 (ptr=0).

Source files
------------

// File: rtl/mod_sub_arbiter.sv
// Round-robin arbiter sharing one modular subtractor (a - b) mod p among NREQ requesters.
// Results are returned through a single-entry output register with valid/ready backpressure.
module mod_sub_arbiter #(
   parameter int unsigned WIDTH = 256,
   parameter int unsigned NREQ  = 4,
   parameter int unsigned IDW   = $clog2(NREQ)
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic [WIDTH-1:0]      p,
   input  logic [NREQ-1:0]       req_valid,
   output logic [NREQ-1:0]       req_ready,
   input  logic [NREQ*WIDTH-1:0] req_a,
   input  logic [NREQ*WIDTH-1:0] req_b,
   output logic                  rsp_valid,
   input  logic                  rsp_ready,
   output logic [IDW-1:0]        rsp_id,
   output logic [WIDTH-1:0]      rsp_diff,
   output logic                  rsp_err,
   output logic [31:0]           op_count
);

   localparam int unsigned IW = IDW + 1;

   typedef enum logic [0:0] {StEmpty, StFull} state_e;

   state_e           state_q;
   logic [IDW-1:0]   ptr_q;
   logic             slot_free;
   logic             gnt_any;
   logic             transfer;
   logic [IDW-1:0]   gnt_id;
   logic [IDW-1:0]   ptr_next;
   logic [WIDTH-1:0] a_sel;
   logic [WIDTH-1:0] b_sel;
   logic [WIDTH-1:0] diff_raw;
   logic [WIDTH-1:0] diff_val;
   logic             err_val;

   assign rsp_valid = (state_q == StFull);
   assign slot_free = !rsp_valid || rsp_ready;

   // Rotating search starting at ptr_q; index kept one bit wider so the wrap is a subtract.
   always_comb begin
      logic [IW-1:0] idx;
      gnt_any = 1'b0;
      gnt_id  = '0;
      idx     = '0;
      for (int unsigned i = 0; i < NREQ; i++) begin
         idx = IW'(ptr_q) + IW'(i);
         if (idx >= IW'(NREQ)) idx = idx - IW'(NREQ);
         if (!gnt_any && req_valid[idx[IDW-1:0]]) begin
            gnt_any = 1'b1;
            gnt_id  = idx[IDW-1:0];
         end
      end
   end

   assign transfer  = slot_free && gnt_any;
   assign req_ready = transfer ? (NREQ'(1) << gnt_id) : '0;
   assign ptr_next  = (gnt_id == IDW'(NREQ - 1)) ? '0 : gnt_id + IDW'(1);

   assign a_sel    = req_a[gnt_id*WIDTH +: WIDTH];
   assign b_sel    = req_b[gnt_id*WIDTH +: WIDTH];
   assign diff_raw = a_sel - b_sel;
   // On borrow, adding p modulo 2^WIDTH cancels the wrapped-around 2^WIDTH.
   assign diff_val = (a_sel >= b_sel) ? diff_raw : diff_raw + p;
   assign err_val  = (a_sel >= p) || (b_sel >= p);

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q  <= StEmpty;
         ptr_q    <= '0;
         rsp_id   <= '0;
         rsp_diff <= '0;
         rsp_err  <= 1'b0;
         op_count <= '0;
      end else begin
         if (rsp_valid && rsp_ready) op_count <= op_count + 32'd1;
         case (state_q)
            StEmpty: if (transfer) state_q <= StFull;
            StFull:  if (rsp_ready && !transfer) state_q <= StEmpty;
            default: state_q <= StEmpty;
         endcase
         if (transfer) begin
            rsp_id   <= gnt_id;
            rsp_diff <= diff_val;
            rsp_err  <= err_val;
            ptr_q    <= ptr_next;
         end
      end
   end

endmodule
